mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: maximum consecutive data grants while a fetch request is pending.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 i_req  input  1  fetch-stage read request; held until i_done or abandoned.
REQ-005 i_addr  input  32  fetch address.
REQ-006 i_rdata  output  32  fetched word; valid in the i_done cycle.
REQ-007 i_done  output  1  one-cycle pulse; fetch transaction complete.
REQ-008 d_req  input  1  memory-stage request; held until d_done.
REQ-009 d_we  input  1  1 = store (STR), 0 = load (LDR).
REQ-010 d_addr  input  32  data address.
REQ-011 d_wdata  input  32  store data.
REQ-012 d_rdata  output  32  load data; valid in the d_done cycle.
REQ-013 d_done  output  1  one-cycle pulse; data transaction complete.
REQ-014 mem_req  output  1  request to the shared single-port memory.
REQ-015 mem_we  output  1  memory write enable.
REQ-016 mem_addr  output  32  memory address.
REQ-017 mem_wdata  output  32  memory write data.
REQ-018 mem_rdata  input  32  memory read data; valid with mem_ack.
REQ-019 mem_ack  input  1  memory completion; arrives 1..N cycles after mem_req rises.
REQ-020 StallF  output  1  freeze fetch stage.
REQ-021 StallM  output  1  freeze memory stage and all older stages.

Function
REQ-022 The FSM SHALL have states IDLE, BUSY_I and BUSY_D.
- IDLE, d_req only: go BUSY_D.
- IDLE, i_req only: go BUSY_I.
- IDLE, both requests: grant data unless starve_cnt == STARVE_LIMIT, in which case grant fetch.
REQ-023 On a grant, the block SHALL register mem_addr, mem_we and mem_wdata and assert mem_req from the next cycle.
- Fetch grant: mem_we=0, mem_wdata=0.
REQ-024 In BUSY_x, mem_req, mem_we, mem_addr and mem_wdata SHALL stay stable until the cycle mem_ack=1.
REQ-025 On mem_ack in BUSY_x, the block SHALL:
- register mem_rdata into x_rdata;
- pulse x_done for exactly one cycle, the cycle after the ack;
- drop mem_req;
- return to IDLE.
REQ-026 Minimum transaction latency SHALL be 3 cycles from request to done (grant, ack, done); there SHALL be one IDLE cycle between transactions.
REQ-027 A store SHALL pulse d_done; d_rdata SHALL be don't-care for a store.
REQ-028 x_rdata SHALL hold its value until the next completion of the same requester.
REQ-029 StallF SHALL equal i_req & ~i_done; StallM SHALL equal d_req & ~d_done.
- Both are combinational from registered done.
REQ-030 starve_cnt (width clog2(STARVE_LIMIT+1)) SHALL behave as follows:
- increment, saturating at STARVE_LIMIT, on each data grant while i_req=1;
- clear on each fetch grant;
- clear in any IDLE cycle with i_req=0.
REQ-031 If i_req falls during BUSY_I (branch flush), the memory transaction SHALL complete, i_done SHALL stay 0 and i_rdata SHALL stay unchanged.
REQ-032 d_req SHALL never be abandoned; d_req falling in BUSY_D is a protocol error and the transaction completes normally.
REQ-033 A request arriving in the ack cycle SHALL be arbitrated in the following IDLE cycle, never the same cycle.
REQ-034 mem_ack received in IDLE SHALL be ignored.

Reset
REQ-035 On reset=1 at a rising edge, the block SHALL enter IDLE, clear starve_cnt, and drive all of the following to 0: mem_req, mem_we, mem_addr, mem_wdata, i_done, d_done, i_rdata, d_rdata.
REQ-036 Reset during BUSY_x SHALL abort the transaction with no done pulse; any later mem_ack SHALL be ignored per REQ-034.
REQ-037 StallF and StallM SHALL follow REQ-029 during reset, so stalls assert if requests are high.

Verification
REQ-038 Single load: d_req=1, d_we=0, d_addr=0x40, ack after 2 cycles with mem_rdata=0xDEADBEEF -> mem_addr=0x40, d_done pulses once, d_rdata=0xDEADBEEF, StallM low after the done cycle.
REQ-039 Contention: i_req and d_req held high, ack latency 1, STARVE_LIMIT=3 -> grant order D,D,D,I,D,D,D,I; StallF high throughout the data grants.
REQ-040 Flush: fetch at i_addr=0x100 granted, i_req dropped before ack -> no i_done, i_rdata unchanged, FSM back to IDLE after ack.
REQ-041 Store: d_we=1, d_addr=0x80, d_wdata=0x12345678 -> mem_we=1 and mem_wdata=0x12345678 stable until ack, d_done pulses once.
REQ-042 Reset mid-BUSY_D, then a stray mem_ack -> all outputs 0, no done pulse, FSM stays IDLE.
REQ-043 Back-to-back fetches (i_req constant, i_addr 0x0 then 0x4) -> exactly one IDLE cycle between transactions, two i_done pulses.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and shared single-port memory bus of the memory port arbiter.
// master drives requests and the memory response; slave is the arbiter.
interface mem_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        StallF;
    logic        StallM;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  i_rdata, i_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata,
               StallF, StallM
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output i_rdata, i_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata,
               StallF, StallM
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data ports; data wins unless fetch has starved STARVE_LIMIT grants.
// Grant in the request cycle, mem_req next cycle, done the cycle after mem_ack; requesters are stalled until done.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_starve_cnt;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic          r_i_done;
    logic          r_d_done;
    logic [31:0]   r_i_rdata;
    logic [31:0]   r_d_rdata;
    logic          r_flushed;
    logic          w_grant_i;
    logic          w_grant_d;
    logic          w_ack_i;
    logic          w_ack_d;

    always_comb begin
        w_next    = r_state;
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        w_ack_i   = 1'b0;
        w_ack_d   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.d_req && !(bus.i_req && r_starve_cnt == LIMIT)) begin
                    w_grant_d = 1'b1;
                    w_next    = BUSY_D;
                end else if (bus.i_req) begin
                    w_grant_i = 1'b1;
                    w_next    = BUSY_I;
                end
            end
            BUSY_I: begin
                if (bus.mem_ack) begin
                    w_ack_i = 1'b1;
                    w_next  = IDLE;
                end
            end
            BUSY_D: begin
                if (bus.mem_ack) begin
                    w_ack_d = 1'b1;
                    w_next  = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_i_done     <= 1'b0;
            r_d_done     <= 1'b0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_flushed    <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;

            if (w_grant_i || w_grant_d) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= w_grant_d & bus.d_we;
                r_mem_addr  <= w_grant_d ? bus.d_addr : bus.i_addr;
                r_mem_wdata <= w_grant_d ? bus.d_wdata : 32'd0;
            end
            if (w_ack_i || w_ack_d) begin
                r_mem_req <= 1'b0;
            end

            // A fetch dropped at any point while in flight is a flush: the data is discarded.
            if (w_grant_i) begin
                r_flushed <= 1'b0;
            end else if (r_state == BUSY_I && !bus.i_req) begin
                r_flushed <= 1'b1;
            end

            if (w_ack_i && bus.i_req && !r_flushed) begin
                r_i_rdata <= bus.mem_rdata;
                r_i_done  <= 1'b1;
            end
            if (w_ack_d) begin
                r_d_rdata <= bus.mem_rdata;
                r_d_done  <= 1'b1;
            end

            if (w_grant_i) begin
                r_starve_cnt <= '0;
            end else if (w_grant_d && bus.i_req) begin
                if (r_starve_cnt != LIMIT) begin
                    r_starve_cnt <= r_starve_cnt + CW'(1);
                end
            end else if (r_state == IDLE && !bus.i_req) begin
                r_starve_cnt <= '0;
            end
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.i_done    = r_i_done;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.d_done    = r_d_done;
    assign bus.StallF    = bus.i_req & ~r_i_done;
    assign bus.StallM    = bus.d_req & ~r_d_done;
endmodule
